// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between NUM_REQ requesters.
// Pending requests are arbitrated round-robin. The winner's op and operands go to the ALU with a
// one-cycle start pulse. The result, or a forced abort after TIMEOUT wait cycles, is returned to
// the winner. Only one operation is in flight at a time, and every output is registered.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins), and
// the round-robin pointer is then not built.
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [2*NUM_REQ-1:0]       req_op,
    input  logic [DATA_W*NUM_REQ-1:0]  req_a,
    input  logic [DATA_W*NUM_REQ-1:0]  req_b,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       timeout_err,
    output logic                       busy,
    output logic                       alu_start,
    output logic [1:0]                 alu_op,
    output logic [DATA_W-1:0]          alu_a,
    output logic [DATA_W-1:0]          alu_b,
    input  logic                       alu_done,
    input  logic [DATA_W-1:0]          alu_result
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    win_reg, win_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
    logic [NUM_REQ-1:0]  rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0]   rsp_data_reg, rsp_data_next;
    logic                timeout_err_reg, timeout_err_next;
    logic                busy_reg, busy_next;
    logic                alu_start_reg, alu_start_next;
    logic [1:0]          alu_op_reg, alu_op_next;
    logic [DATA_W-1:0]   alu_a_reg, alu_a_next;
    logic [DATA_W-1:0]   alu_b_reg, alu_b_next;
    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [IDX_W:0]      cand;
`endif

    // Winner select: scan downward so that the candidate closest to the search start wins last
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(k);
            end
        end
`else
        cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_reg} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (req[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
`endif
    end

    // Next-state and next-output logic; registered outputs default to idle values each cycle
    always_comb begin
        state_next       = state_reg;
        win_next         = win_reg;
        cnt_next         = cnt_reg;
        gnt_next         = '0;
        rsp_valid_next   = '0;
        rsp_data_next    = '0;
        timeout_err_next = 1'b0;
        alu_start_next   = 1'b0;
        alu_op_next      = alu_op_reg;
        alu_a_next       = alu_a_reg;
        alu_b_next       = alu_b_reg;
`ifndef ALU_ARB_FIXED_PRIO_EN
        rr_ptr_next      = rr_ptr_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (win_found) begin
                    state_next     = ST_ISSUE;
                    win_next       = win_idx;
                    gnt_next       = ONE_HOT0 << win_idx;
                    alu_start_next = 1'b1;
                    alu_op_next    = req_op[2*int'(win_idx) +: 2];
                    alu_a_next     = req_a[DATA_W*int'(win_idx) +: DATA_W];
                    alu_b_next     = req_b[DATA_W*int'(win_idx) +: DATA_W];
                end
            end
            ST_ISSUE: begin
                if (alu_done) begin
                    state_next     = ST_RESP;
                    rsp_valid_next = ONE_HOT0 << win_reg;
                    rsp_data_next  = alu_result;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A completion on the last allowed cycle still counts as a normal response
                if (alu_done) begin
                    state_next     = ST_RESP;
                    rsp_valid_next = ONE_HOT0 << win_reg;
                    rsp_data_next  = alu_result;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next       = ST_RESP;
                    rsp_valid_next   = ONE_HOT0 << win_reg;
                    timeout_err_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
                rr_ptr_next = (win_reg == IDX_W'(NUM_REQ - 1)) ? '0 : win_reg + 1'b1;
`endif
            end
        endcase
        busy_next = (state_next != ST_IDLE);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath and output registers; reset drops any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_reg         <= '0;
            cnt_reg         <= '0;
            gnt_reg         <= '0;
            rsp_valid_reg   <= '0;
            rsp_data_reg    <= '0;
            timeout_err_reg <= 1'b0;
            busy_reg        <= 1'b0;
            alu_start_reg   <= 1'b0;
            alu_op_reg      <= '0;
            alu_a_reg       <= '0;
            alu_b_reg       <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_ptr_reg      <= '0;
`endif
        end else begin
            win_reg         <= win_next;
            cnt_reg         <= cnt_next;
            gnt_reg         <= gnt_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_data_reg    <= rsp_data_next;
            timeout_err_reg <= timeout_err_next;
            busy_reg        <= busy_next;
            alu_start_reg   <= alu_start_next;
            alu_op_reg      <= alu_op_next;
            alu_a_reg       <= alu_a_next;
            alu_b_reg       <= alu_b_next;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_ptr_reg      <= rr_ptr_next;
`endif
        end
    end

    assign gnt         = gnt_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_data    = rsp_data_reg;
    assign timeout_err = timeout_err_reg;
    assign busy        = busy_reg;
    assign alu_start   = alu_start_reg;
    assign alu_op      = alu_op_reg;
    assign alu_a       = alu_a_reg;
    assign alu_b       = alu_b_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter (NUM_REQ=2, DATA_W=8, TIMEOUT=8).
// Includes a small ALU model with a programmable completion delay, a zero-wait mode and a
// never-complete mode. Inputs are driven and outputs are sampled on the falling clock edge.
module tb_alu_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [3:0] req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [1:0] gnt;
    logic [1:0] rsp_valid;
    logic [7:0] rsp_data;
    logic       timeout_err;
    logic       busy;
    logic       alu_start;
    logic [1:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_done;
    logic [7:0] alu_result;

    int n_cmp = 0;
    int n_mis = 0;
    int lat;
    int stray;

    // ALU model state
    logic [7:0] alu_cnt = 8'd0;
    int         alu_delay = 0;
    bit         zero_wait = 1'b0;

    alu_arbiter #(.NUM_REQ(2), .DATA_W(8), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .timeout_err(timeout_err),
        .busy(busy), .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU completion timer: done arrives alu_delay cycles after the start cycle (0 = never)
    always @(posedge clk) begin
        if (alu_start) alu_cnt <= 8'(alu_delay);
        else if (alu_cnt != 8'd0) alu_cnt <= alu_cnt - 8'd1;
    end
    assign alu_done = zero_wait ? alu_start : (alu_cnt == 8'd1);

    // ALU function
    always_comb begin
        alu_result = 8'h00;
        case (alu_op)
            2'b00: alu_result = alu_a + alu_b;
            2'b01: alu_result = alu_a - alu_b;
            2'b10: alu_result = alu_a & alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step falling edges until a response appears (bounded); n = cycles after the grant cycle
    task automatic wait_rsp(input int max_cyc, output int n);
        @(negedge clk);
        n = 1;
        while (rsp_valid == 2'b00 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Step falling edges until a grant appears (bounded)
    task automatic wait_gnt(input int max_cyc, output int n);
        @(negedge clk);
        n = 1;
        while (gnt == 2'b00 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 2'b00; req_op = 4'h0; req_a = 16'h0; req_b = 16'h0;

        // T1: reset state
        @(negedge clk);
        check("rst_gnt", gnt, 2'b00);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_alu_start", alu_start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_rsp_data", rsp_data, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_gnt", gnt, 2'b00);

        // T2: single ADD from requester 0, ALU done 2 cycles after start
        req_op[1:0] = 2'b00; req_a[7:0] = 8'd3; req_b[7:0] = 8'd5; alu_delay = 2; req = 2'b01;
        @(negedge clk);
        check("t2_gnt", gnt, 2'b01);
        check("t2_alu_start", alu_start, 1'b1);
        check("t2_alu_op", alu_op, 2'b00);
        check("t2_alu_a", alu_a, 8'd3);
        check("t2_alu_b", alu_b, 8'd5);
        check("t2_busy", busy, 1'b1);
        req = 2'b00;
        wait_rsp(20, lat);
        $display("txn T2 rsp_valid=%b rsp_data=%02h timeout_err=%b latency=%0d", rsp_valid, rsp_data, timeout_err, lat);
        check("t2_latency", lat, 3);
        check("t2_rsp_valid", rsp_valid, 2'b01);
        check("t2_rsp_data", rsp_data, 8'h08);
        check("t2_timeout_err", timeout_err, 1'b0);
        @(negedge clk);
        check("t2_idle_busy", busy, 1'b0);
        check("t2_rsp_pulse", rsp_valid, 2'b00);

        // T4: requester 1, ALU never completes -> abort after 8 wait cycles
        alu_delay = 0; req_op[3:2] = 2'b00; req_a[15:8] = 8'h11; req_b[15:8] = 8'h22; req = 2'b10;
        @(negedge clk);
        check("t4_gnt", gnt, 2'b10);
        req = 2'b00;
        wait_rsp(20, lat);
        $display("txn T4 rsp_valid=%b rsp_data=%02h timeout_err=%b latency=%0d", rsp_valid, rsp_data, timeout_err, lat);
        check("t4_latency", lat, 9);
        check("t4_rsp_valid", rsp_valid, 2'b10);
        check("t4_rsp_data", rsp_data, 8'h00);
        check("t4_timeout_err", timeout_err, 1'b1);
        check("t4_alu_a_held", alu_a, 8'h11);
        @(negedge clk);
        check("t4_timeout_pulse", timeout_err, 1'b0);

        // T3: both requesters held
        req_op = 4'b10_01; req_a = 16'hF0_09; req_b = 16'h3C_04; alu_delay = 2; req = 2'b11;
        @(negedge clk);
        check("t3_gnt0", gnt, 2'b01);
        check("t3_alu_op0", alu_op, 2'b01);
        check("t3_alu_a0", alu_a, 8'h09);
        wait_rsp(20, lat);
        $display("txn T3a rsp_valid=%b rsp_data=%02h timeout_err=%b latency=%0d", rsp_valid, rsp_data, timeout_err, lat);
        check("t3_rsp_valid0", rsp_valid, 2'b01);
        check("t3_rsp_data0", rsp_data, 8'h05);
        wait_gnt(10, lat);
        check("t3_gnt_spacing", lat, 2);
`ifdef ALU_ARB_FIXED_PRIO_EN
        check("t3_gnt1", gnt, 2'b01);
        check("t3_alu_b1", alu_b, 8'h04);
`else
        check("t3_gnt1", gnt, 2'b10);
        check("t3_alu_b1", alu_b, 8'h3C);
`endif
        req = 2'b00;
        wait_rsp(20, lat);
        $display("txn T3b rsp_valid=%b rsp_data=%02h timeout_err=%b latency=%0d", rsp_valid, rsp_data, timeout_err, lat);
`ifdef ALU_ARB_FIXED_PRIO_EN
        check("t3_rsp_valid1", rsp_valid, 2'b01);
        check("t3_rsp_data1", rsp_data, 8'h05);
`else
        check("t3_rsp_valid1", rsp_valid, 2'b10);
        check("t3_rsp_data1", rsp_data, 8'h30);
`endif
        @(negedge clk);
        check("t3_idle_busy", busy, 1'b0);

        // T5: zero-wait ALU, OR
        zero_wait = 1'b1; alu_delay = 0;
        req_op[1:0] = 2'b11; req_a[7:0] = 8'h0A; req_b[7:0] = 8'h05; req = 2'b01;
        @(negedge clk);
        check("t5_gnt", gnt, 2'b01);
        req = 2'b00;
        wait_rsp(20, lat);
        $display("txn T5 rsp_valid=%b rsp_data=%02h timeout_err=%b latency=%0d", rsp_valid, rsp_data, timeout_err, lat);
        check("t5_latency", lat, 1);
        check("t5_rsp_valid", rsp_valid, 2'b01);
        check("t5_rsp_data", rsp_data, 8'h0F);
        zero_wait = 1'b0;
        @(negedge clk);

        // T6: reset pulsed during WAIT drops the operation
        alu_delay = 0; req = 2'b01;
        @(negedge clk);
        check("t6_gnt", gnt, 2'b01);
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("t6_busy_wait", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_alu_a", alu_a, 8'h00);
        check("t6_rst_alu_op", alu_op, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) stray++;
        end
        check("t6_no_rsp", stray, 0);
        req_op[3:2] = 2'b00; req_a[15:8] = 8'h20; req_b[15:8] = 8'h07; alu_delay = 2; req = 2'b10;
        @(negedge clk);
        check("t6_gnt_after_rst", gnt, 2'b10);
        req = 2'b00;
        wait_rsp(20, lat);
        $display("txn T6 rsp_valid=%b rsp_data=%02h timeout_err=%b latency=%0d", rsp_valid, rsp_data, timeout_err, lat);
        check("t6_rsp_valid", rsp_valid, 2'b10);
        check("t6_rsp_data", rsp_data, 8'h27);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
